ppm_tx: RTL and testbench

PPM_TX -- requirements
Module: ppm_tx

---
 rtl/ppm_tx_pkg.sv | 28 ++
 rtl/ppm_tx_chip_counter.sv | 35 +++
 rtl/ppm_tx.sv | 148 ++++++++++++++
 tb/tb_ppm_tx.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ppm_tx_pkg.sv
// Shared PPM definitions (state encodings, pulse positions, symbol width) used by tx and rx.
// The SFD state exists only when PPM_TX_SFD_EN is defined.
package ppm_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
`ifdef PPM_TX_SFD_EN
    ST_SFD      = 3'd2,
`endif
    ST_DATA     = 3'd3,
    ST_GUARD    = 3'd4
  } ppm_state_e;

  function automatic int unsigned ppm_sym_bits(input int unsigned chips);
    return $clog2(chips);
  endfunction

  // Preamble pulses land at chip 0 and at this chip.
  function automatic int unsigned ppm_pre_chip_b(input int unsigned chips);
    return chips / 2;
  endfunction

  function automatic int unsigned ppm_sfd_chip(input int unsigned chips);
    return chips - 1;
  endfunction

endpackage

// File: rtl/ppm_tx_chip_counter.sv
// Chip counter (0..CHIPS-1, wrapping) plus preamble symbol down-counter with terminal flag.
// Both counters are held at their start values while en is low.
module ppm_chip_counter #(
  parameter  int CHIPS = 16,
  parameter  int SYMS  = 8,
  localparam int CW    = $clog2(CHIPS)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          en,
  output logic [CW-1:0] chip,
  output logic          chip_wrap,
  output logic          sym_tc
);

  logic [7:0] sym_left;

  assign chip_wrap = en && (chip == CW'(CHIPS - 1));
  assign sym_tc    = chip_wrap && (sym_left == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      chip     <= '0;
      sym_left <= '0;
    end else if (!en) begin
      chip     <= '0;
      sym_left <= 8'(SYMS - 1);
    end else begin
      chip <= chip + 1'b1;
      if (chip_wrap && (sym_left != '0))
        sym_left <= sym_left - 1'b1;
    end
  end

endmodule

// File: rtl/ppm_tx.sv
// PPM frame transmitter: preamble, optional SFD (PPM_TX_SFD_EN), data symbols, guard.
// state       | meaning
// ST_IDLE     | waiting for start
// ST_PREAMBLE | PREAMBLE_SYMBOLS symbols, pulses at chip 0 and mid-symbol
// ST_SFD      | one symbol, pulse at last chip (PPM_TX_SFD_EN only)
// ST_DATA     | one pulse per symbol at chip == symbol value; empty slot is an erasure
// ST_GUARD    | one symbol of silence, then IDLE with done
module ppm_tx
  import ppm_tx_pkg::*;
#(
  parameter  int CHIP_BITS        = 1,
  parameter  int SYMBOL_CHIPS     = 16,
  parameter  int PREAMBLE_SYMBOLS = 8,
  localparam int SYM_BITS         = ppm_sym_bits(SYMBOL_CHIPS)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [SYM_BITS-1:0]  sym_data,
  input  logic                 sym_valid,
  input  logic                 sym_last,
  output logic                 sym_ready,
  output logic [CHIP_BITS-1:0] dout,
  output logic                 busy,
  output logic                 preamble_active,
  output logic                 underrun,
  output logic                 done
);

  localparam logic [SYM_BITS-1:0] PRE_CHIP_B = SYM_BITS'(ppm_pre_chip_b(SYMBOL_CHIPS));
`ifdef PPM_TX_SFD_EN
  localparam logic [SYM_BITS-1:0] SFD_CHIP = SYM_BITS'(ppm_sfd_chip(SYMBOL_CHIPS));
`endif

  ppm_state_e          state, next_state;
  logic [SYM_BITS-1:0] chip;
  logic                chip_wrap, sym_tc;
  logic                hold_valid, hold_last, cur_valid, cur_last, last_acc, done_pend;
  logic [SYM_BITS-1:0] hold_data, cur_data;
  logic                pulse, pre_c, load, in_frame, xfer;

  assign busy = (state != ST_IDLE);
  assign xfer = sym_valid && sym_ready;

  ppm_chip_counter #(
    .CHIPS (SYMBOL_CHIPS),
    .SYMS  (PREAMBLE_SYMBOLS)
  ) u_cnt (
    .clk       (clk),
    .resetn    (resetn),
    .en        (busy),
    .chip      (chip),
    .chip_wrap (chip_wrap),
    .sym_tc    (sym_tc)
  );

  always_comb begin
    next_state = state;
    pulse      = 1'b0;
    pre_c      = 1'b0;
    load       = 1'b0;
    in_frame   = 1'b0;
    case (state)
      ST_IDLE: if (start) next_state = ST_PREAMBLE;
      ST_PREAMBLE: begin
        in_frame = 1'b1;
        pre_c    = 1'b1;
        pulse    = (chip == '0) || (chip == PRE_CHIP_B);
        if (sym_tc) begin
`ifdef PPM_TX_SFD_EN
          next_state = ST_SFD;
`else
          next_state = ST_DATA;
          load       = 1'b1;
`endif
        end
      end
`ifdef PPM_TX_SFD_EN
      ST_SFD: begin
        in_frame = 1'b1;
        pre_c    = 1'b1;
        pulse    = (chip == SFD_CHIP);
        if (chip_wrap) begin
          next_state = ST_DATA;
          load       = 1'b1;
        end
      end
`endif
      ST_DATA: begin
        in_frame = 1'b1;
        pulse    = cur_valid && (chip == cur_data);
        if (chip_wrap) begin
          if (cur_valid && cur_last) next_state = ST_GUARD;
          else                       load       = 1'b1;
        end
      end
      ST_GUARD: if (chip_wrap) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
    sym_ready = in_frame && !hold_valid && !last_acc;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= ST_IDLE;
      dout            <= '0;
      preamble_active <= 1'b0;
      underrun        <= 1'b0;
      done_pend       <= 1'b0;
      done            <= 1'b0;
      hold_valid      <= 1'b0;
      hold_data       <= '0;
      hold_last       <= 1'b0;
      cur_valid       <= 1'b0;
      cur_data        <= '0;
      cur_last        <= 1'b0;
      last_acc        <= 1'b0;
    end else begin
      state           <= next_state;
      dout            <= {CHIP_BITS{pulse}};
      preamble_active <= pre_c;
      // done trails the last guard chip through the same output stage as dout
      done_pend       <= (state == ST_GUARD) && chip_wrap;
      done            <= done_pend;
      if ((state == ST_IDLE) && start) begin
        underrun   <= 1'b0;
        last_acc   <= 1'b0;
        hold_valid <= 1'b0;
      end else begin
        if (load) begin
          cur_valid <= hold_valid;
          cur_data  <= hold_data;
          cur_last  <= hold_last;
          if (!hold_valid) underrun <= 1'b1;
        end
        if (xfer) begin
          hold_valid <= 1'b1;
          hold_data  <= sym_data;
          hold_last  <= sym_last;
          if (sym_last) last_acc <= 1'b1;
        end else if (load) begin
          hold_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ppm_tx.sv
// Scoreboard bench for ppm_tx: expected pulse cycles queued per frame, popped on each DUT pulse.
// Cycle c is the value visible after the c-th rising edge, the edge that samples start being edge 0.
module tb_ppm_tx;

  localparam int SYM_BITS = 4;
`ifdef PPM_TX_SFD_EN
  localparam int DOFF = 16;
`else
  localparam int DOFF = 0;
`endif

  logic                clk, resetn, start, sym_valid, sym_last;
  logic [SYM_BITS-1:0] sym_data;
  logic                sym_ready, busy, preamble_active, underrun, done;
  logic [0:0]          dout;

  typedef struct { int data; bit last; int avail; } sym_t;
  sym_t syms[$];
  int   exp_pulse[$];
  int   n_chk, n_fail;

  ppm_tx dut (
    .clk             (clk),
    .resetn          (resetn),
    .start           (start),
    .sym_data        (sym_data),
    .sym_valid       (sym_valid),
    .sym_last        (sym_last),
    .sym_ready       (sym_ready),
    .dout            (dout),
    .busy            (busy),
    .preamble_active (preamble_active),
    .underrun        (underrun),
    .done            (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_eq(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic add_sym(input int data, input bit last, input int avail);
    sym_t s;
    s.data = data; s.last = last; s.avail = avail;
    syms.push_back(s);
  endtask

  task automatic push_preamble();
    for (int k = 0; k < 16; k++) exp_pulse.push_back(1 + 8 * k);
`ifdef PPM_TX_SFD_EN
    exp_pulse.push_back(144);
`endif
  endtask

  task automatic drive_sym(input int c);
    if (syms.size() > 0 && syms[0].avail <= c) begin
      sym_valid = 1'b1;
      sym_data  = SYM_BITS'(syms[0].data);
      sym_last  = syms[0].last;
    end else begin
      sym_valid = 1'b0;
      sym_last  = 1'b0;
    end
    if (sym_valid && sym_ready) void'(syms.pop_front());
  endtask

  task automatic run_frame(input string tag, input int exp_done, input bit exp_urun,
                           input int start_at, input int reset_at);
    int c;
    bit seen_done;
    c = -1;
    seen_done = 1'b0;
    @(negedge clk);
    start = 1'b1;
    drive_sym(c);
    while (1) begin
      @(negedge clk);
      c++;
      if (dout != '0) begin
        if (exp_pulse.size() > 0) chk_eq({tag, "_pulse_cycle"}, c, exp_pulse.pop_front());
        else                      chk_eq({tag, "_extra_pulse_cycle"}, c, -1);
      end
      if (c == 0) begin
        chk_eq({tag, "_busy_c0"}, int'(busy), 1);
        chk_eq({tag, "_pre_act_c0"}, int'(preamble_active), 0);
      end
      if (c == 1 || c == 128 + DOFF) chk_eq({tag, "_pre_act_hi"}, int'(preamble_active), 1);
      if (c == 129 + DOFF)           chk_eq({tag, "_pre_act_lo"}, int'(preamble_active), 0);
      if (done) begin
        seen_done = 1'b1;
        chk_eq({tag, "_done_cycle"}, c, exp_done);
      end
      if (exp_done >= 0 && c == exp_done - 5) chk_eq({tag, "_ready_guard"}, int'(sym_ready), 0);
      if (c == exp_done) begin
        chk_eq({tag, "_busy_end"}, int'(busy), 0);
        chk_eq({tag, "_underrun"}, int'(underrun), int'(exp_urun));
      end
      if (c == reset_at) begin
        chk_eq({tag, "_pre_rst_dout"}, int'(dout), 1);
        chk_eq({tag, "_pre_rst_busy"}, int'(busy), 1);
        chk_eq({tag, "_pre_rst_ready"}, int'(sym_ready), 1);
        chk_eq({tag, "_pre_rst_underrun"}, int'(underrun), 1);
        #2 resetn = 1'b0;
        #1;
        chk_eq({tag, "_rst_dout"}, int'(dout), 0);
        chk_eq({tag, "_rst_busy"}, int'(busy), 0);
        chk_eq({tag, "_rst_ready"}, int'(sym_ready), 0);
        chk_eq({tag, "_rst_underrun"}, int'(underrun), 0);
        break;
      end
      if (exp_done >= 0 && c == exp_done + 2) break;
      if (c > 400) begin
        chk_eq({tag, "_timeout_cycle"}, c, exp_done);
        break;
      end
      start = (c == start_at);
      drive_sym(c);
    end
    if (reset_at < 0) chk_eq({tag, "_done_seen"}, int'(seen_done), 1);
    chk_eq({tag, "_missing_pulses"}, exp_pulse.size(), 0);
    exp_pulse.delete();
    syms.delete();
    start     = 1'b0;
    sym_valid = 1'b0;
    sym_last  = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    resetn = 1'b0; start = 1'b0; sym_valid = 1'b0; sym_last = 1'b0; sym_data = '0;
    #1;
    chk_eq("reset_dout", int'(dout), 0);
    chk_eq("reset_busy", int'(busy), 0);
    chk_eq("reset_ready", int'(sym_ready), 0);
    chk_eq("reset_done", int'(done), 0);
    chk_eq("reset_pre_act", int'(preamble_active), 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // sym_valid in IDLE must be ignored
    sym_valid = 1'b1; sym_data = 4'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_eq("idle_ready", int'(sym_ready), 0);
    end
    sym_valid = 1'b0;

    // prefetched 3, 15, 0(last)
    push_preamble();
    exp_pulse.push_back(132 + DOFF);
    exp_pulse.push_back(160 + DOFF);
    exp_pulse.push_back(161 + DOFF);
    add_sym(3, 0, -1); add_sym(15, 0, -1); add_sym(0, 1, -1);
    run_frame("basic", 193 + DOFF, 1'b0, -1, -1);

    // second symbol withheld -> erasure slot; stray start at cycle 50
    push_preamble();
    exp_pulse.push_back(132 + DOFF);
    exp_pulse.push_back(170 + DOFF);
    exp_pulse.push_back(182 + DOFF);
    add_sym(3, 0, -1); add_sym(9, 0, 150 + DOFF); add_sym(5, 1, 150 + DOFF);
    run_frame("underrun", 209 + DOFF, 1'b1, 50, -1);

    // first slot erased, symbol 4 in second slot, reset while its pulse is on dout
    push_preamble();
    exp_pulse.push_back(149 + DOFF);
    add_sym(4, 0, 130 + DOFF);
    run_frame("reset", -1, 1'b1, -1, 149 + DOFF);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk_eq("post_rst_busy", int'(busy), 0);

    // a fresh frame after the abandoned one starts from the preamble
    push_preamble();
    exp_pulse.push_back(138 + DOFF);
    exp_pulse.push_back(145 + DOFF);
    add_sym(9, 0, -1); add_sym(0, 1, -1);
    run_frame("restart", 177 + DOFF, 1'b0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
